// File: rtl/ifft_twiddle_sequencer_if.sv
// Handshake bundle between IFFT control, butterfly unit and twiddle sequencer.
// Ports: start/abort/bf_ready in, rom_addr/tw_valid/tw_stage/tw_bfly/busy/done out.
interface ifft_twiddle_sequencer_if #(
   parameter int STAGES = 4,
   parameter int BFLY   = 8,
   parameter int ADDR_W = 5
) ();
   localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int BW = (BFLY > 1) ? $clog2(BFLY) : 1;

   logic              start;
   logic              abort;
   logic              bf_ready;
   logic [ADDR_W-1:0] rom_addr;
   logic              tw_valid;
   logic [SW-1:0]     tw_stage;
   logic [BW-1:0]     tw_bfly;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, bf_ready,
      input  rom_addr, tw_valid, tw_stage, tw_bfly, busy, done
   );

   modport slave (
      input  start, abort, bf_ready,
      output rom_addr, tw_valid, tw_stage, tw_bfly, busy, done
   );
endinterface

// File: rtl/ifft_twiddle_sequencer.sv
// Walks all IFFT stages/butterflies, addressing the shared twiddle ROMs.
// Ports: clk, rst (sync, active-high), bus (slave: start/abort/bf_ready -> rom_addr/tw_*/busy/done).
module ifft_twiddle_sequencer #(
   parameter int STAGES = 4,
   parameter int BFLY   = 8,
   parameter int ADDR_W = 5,
   parameter int GAP    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   ifft_twiddle_sequencer_if.slave   bus
);
   localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int BW = (BFLY > 1) ? $clog2(BFLY) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [BW-1:0] bfly_q, bfly_d;
   logic [GW-1:0] gap_q, gap_d;

   logic last_b;
   logic last_s;

   function automatic logic [ADDR_W-1:0] addr_of(
      input logic [SW-1:0] s,
      input logic [BW-1:0] b
   );
      return ADDR_W'(s) * ADDR_W'(BFLY) + ADDR_W'(b);
   endfunction

   assign last_b = (bfly_q == BW'(BFLY - 1));
   assign last_s = (stage_q == SW'(STAGES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         bfly_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      stage_d      = stage_q;
      bfly_d       = bfly_q;
      gap_d        = gap_q;
      bus.rom_addr = '0;
      bus.tw_valid = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            bus.done = (state_q == DONE);
            state_d  = IDLE;
            if (bus.start) begin
               state_d = LOAD;
               stage_d = '0;
               bfly_d  = '0;
               gap_d   = GW'(GAP - 1);
            end
         end
         LOAD: begin
            bus.busy     = 1'b1;
            bus.rom_addr = addr_of(stage_q, '0);
            if (gap_q == '0) begin
               state_d = RUN;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         RUN: begin
            bus.busy     = 1'b1;
            bus.tw_valid = 1'b1;
            // Without a fire the ROM re-reads the same entry, keeping data stable.
            bus.rom_addr = addr_of(stage_q, bfly_q);
            if (bus.bf_ready) begin
               if (!last_b) begin
                  // Look one entry ahead so the next twiddle lands with no bubble.
                  bfly_d       = bfly_q + BW'(1);
                  bus.rom_addr = addr_of(stage_q, bfly_q) + ADDR_W'(1);
               end else if (!last_s) begin
                  state_d = LOAD;
                  stage_d = stage_q + SW'(1);
                  bfly_d  = '0;
                  gap_d   = GW'(GAP - 1);
               end else begin
                  state_d = DONE;
                  stage_d = '0;
                  bfly_d  = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (bus.abort) begin
         state_d = IDLE;
         stage_d = '0;
         bfly_d  = '0;
         gap_d   = '0;
      end
   end

   assign bus.tw_stage = stage_q;
   assign bus.tw_bfly  = bfly_q;
endmodule

// File: doc/ifft_twiddle_sequencer.md
# ifft_twiddle_sequencer

Sequences the IFFT twiddle-factor ROMs for one transform: walks every stage and butterfly of a radix-2 IFFT, drives the 5-bit ROM address, and tells the butterfly unit when the ROM output is a valid twiddle. It accounts for the ROM's one-cycle registered read latency and honours butterfly back-pressure. It sits between the IFFT top-level control, which issues `start` and receives `done`, and the `twiddle_ROM_*` instances, which all share one `rom_addr`.

## Interface
- STAGES, default 4: IFFT stages per transform (log2 N).
- BFLY, default 8: butterflies per stage (N/2).
- ADDR_W, default 5: ROM address width; must satisfy STAGES*BFLY <= 2^ADDR_W.
- GAP, default 1: load cycles before each stage (>=1; covers ROM latency and memory turnaround).

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; ignored while busy.
- abort  in  1  synchronous cancel; returns to IDLE without `done`.
- bf_ready  in  1  butterfly accepts the current twiddle.
- rom_addr  out  ADDR_W  address to all twiddle ROMs (combinational, see Operation).
- tw_valid  out  1  ROM data_out holds the twiddle for (tw_stage, tw_bfly).
- tw_stage  out  clog2(STAGES)  stage index of the current twiddle.
- tw_bfly  out  clog2(BFLY)  butterfly index within the stage.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse after the last twiddle is accepted.

## Operation
- Address map: addr = stage*BFLY + bfly; with defaults, {stage[1:0], bfly[2:0]}.
- Registered pointer (stage, bfly) is the entry whose data is on the ROM output during RUN.
- fire = tw_valid & bf_ready.
- States:
  - IDLE: rom_addr=0, outputs low. `start` -> LOAD with stage=0, bfly=0, gap_cnt=GAP-1.
  - LOAD: rom_addr=addr(stage,0), tw_valid=0. gap_cnt decrements; at 0 -> RUN.
  - RUN: tw_valid=1.
    - No fire: hold the pointer; rom_addr=addr(stage,bfly), so the ROM re-reads the same entry and the data stays stable.
    - Fire with bfly<BFLY-1: bfly++; rom_addr=addr(stage,bfly+1) in the same cycle, so the next data is ready one cycle later with no bubble.
    - Fire on the last bfly with stage<STAGES-1: stage++, bfly=0, gap_cnt=GAP-1 -> LOAD.
    - Fire on the last bfly of the last stage -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- rom_addr in RUN is combinational from the pointer and bf_ready. This bf_ready-to-ROM-address path is intended.
- `abort` or `rst` in any state: next cycle IDLE with all outputs at reset values and no `done`; priority rst > abort > start.
- `start` in DONE or IDLE is accepted. `start` in LOAD or RUN is ignored.
- Index wrap: bfly and stage counters compare against BFLY-1 and STAGES-1. They never wrap past them, and no address >= STAGES*BFLY is ever issued.

## Timing
- Reset values: rom_addr=0, tw_valid=0, tw_stage=0, tw_bfly=0, busy=0, done=0, state IDLE.
- Start sampled at cycle 0: LOAD occupies cycles 1..GAP, first tw_valid in cycle GAP+1.
- A stage with bf_ready held high takes GAP + BFLY cycles. The final fire is at cycle STAGES*(GAP+BFLY) and `done` is in the next cycle; with defaults, `done` is at cycle 37.
- Each cycle with bf_ready low in RUN adds exactly one cycle of latency.
- tw_stage and tw_bfly are valid whenever tw_valid=1. In LOAD they show the upcoming stage and bfly 0.

## Test plan
- Reset, then start at cycle 0 with bf_ready=1, defaults -> rom_addr sequence 0..7 (cycle 1 LOAD, 1..7 in RUN), 8..15, 16..23, 24..31. tw_valid=0 at cycles 1, 10, 19, 28. done=1 only at cycle 37, busy high for cycles 1..36.
- bf_ready low for 3 cycles at stage 1, bfly 5 -> rom_addr holds 13 and tw_valid stays 1 during the stall. Next fire advances to 14; done arrives 3 cycles later (cycle 40).
- start pulsed again at cycle 15 while busy -> no effect, done still at cycle 37. start in the same cycle as done -> a new transform begins with LOAD next cycle.
- abort at stage 2, bfly 3 -> next cycle busy=0, tw_valid=0, rom_addr=0, and no done. A following start restarts at address 0.
- rst asserted mid-RUN together with start -> all outputs take reset values next cycle and stay in IDLE.
- GAP=3 -> three LOAD cycles before each stage with rom_addr at the stage base, and done at cycle 45.
